// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction issue path between host and vector Cpu.
package cpu_pkg;

    localparam logic [2:0] OP_INIT      = 3'b100;
    localparam logic [2:0] OP_NOP       = 3'b111;
    localparam logic [2:0] OP_MAX_LEGAL = 3'b100;

    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned VEC_W  = 512;
    localparam int unsigned MEM_AW = 9;
    localparam int unsigned REG_AW = 2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StGap
    } issue_state_e;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [REG_AW-1:0] reg_addr;
        logic [MEM_AW-1:0] mem_address;
        logic [VEC_W-1:0]  init_value;
    } iq_entry_t;

    function automatic logic is_legal(input logic [2:0] op);
        return op <= OP_MAX_LEGAL;
    endfunction

endpackage

// File: rtl/iq_fifo.sv
// Instruction storage ring with occupancy count; storage itself is deliberately left unreset.
module iq_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  iq_entry_t              wdata,
    input  logic                   pop,
    output iq_entry_t              rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_MAX = DEPTH[PW:0];

    iq_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Buffers host instructions and issues them to the Cpu one at a time, with an optional
// NOP gap after each issue; illegal opcodes are acknowledged and reported but never stored.
module instr_issue_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ISSUE_GAP = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_opcode,
    input  logic [REG_AW-1:0]      in_reg_addr,
    input  logic [MEM_AW-1:0]      in_mem_address,
    input  logic [VEC_W-1:0]       in_init_value,
    input  logic                   flush,
    output logic [2:0]             instruction,
    output logic [REG_AW-1:0]      reg_addr,
    output logic [MEM_AW-1:0]      mem_address,
    output logic [VEC_W-1:0]       initialize_value,
    output logic                   issued,
    output logic                   illegal,
    output logic [$clog2(DEPTH):0] count
);

    localparam logic [3:0] GAP_LOAD = (ISSUE_GAP > 0) ? 4'(ISSUE_GAP - 1) : 4'd0;

    issue_state_e state;
    logic [3:0]   gap_cnt;
    iq_entry_t    wdata;
    iq_entry_t    head;
    logic         full;
    logic         empty;
    logic         accept;
    logic         push;
    logic         pop_slot;
    logic         pop;

    assign in_ready = !full;
    assign accept   = in_valid && in_ready && !flush;
    assign push     = accept && is_legal(in_opcode);

    always_comb begin
        wdata             = '0;
        wdata.opcode      = in_opcode;
        wdata.reg_addr    = in_reg_addr;
        wdata.mem_address = in_mem_address;
        wdata.init_value  = (in_opcode == OP_INIT) ? in_init_value : '0;
    end

    // A pop may happen from IDLE, straight out of ISSUE when there is no gap, or at gap end.
    always_comb begin
        pop_slot = 1'b0;
        unique case (state)
            StIdle:  pop_slot = 1'b1;
            StIssue: pop_slot = (ISSUE_GAP == 0);
            StGap:   pop_slot = (gap_cnt == 4'd0);
            default: pop_slot = 1'b0;
        endcase
    end

    assign pop = pop_slot && !empty && !flush;

    iq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= StIdle;
            gap_cnt          <= 4'd0;
            instruction      <= OP_NOP;
            reg_addr         <= '0;
            mem_address      <= '0;
            initialize_value <= '0;
            issued           <= 1'b0;
            illegal          <= 1'b0;
        end else if (flush) begin
            state            <= StIdle;
            gap_cnt          <= 4'd0;
            instruction      <= OP_NOP;
            reg_addr         <= '0;
            mem_address      <= '0;
            initialize_value <= '0;
            issued           <= 1'b0;
            illegal          <= 1'b0;
        end else begin
            illegal <= accept && !is_legal(in_opcode);
            if (pop) begin
                state            <= StIssue;
                instruction      <= head.opcode;
                reg_addr         <= head.reg_addr;
                mem_address      <= head.mem_address;
                initialize_value <= head.init_value;
                issued           <= 1'b1;
            end else begin
                instruction      <= OP_NOP;
                reg_addr         <= '0;
                mem_address      <= '0;
                initialize_value <= '0;
                issued           <= 1'b0;
                unique case (state)
                    StIssue: begin
                        if (ISSUE_GAP != 0) begin
                            state   <= StGap;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= StIdle;
                        end
                    end
                    StGap: begin
                        if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
                        else                 state   <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench: one queue with no issue gap and one with a 3-cycle gap share the stimulus.
module tb_instr_issue_queue;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [2:0]   in_opcode = 3'd0;
    logic [1:0]   in_reg_addr = 2'd0;
    logic [8:0]   in_mem_address = 9'd0;
    logic [511:0] in_init_value = '0;
    logic         flush = 1'b0;

    logic         a_in_ready, a_issued, a_illegal;
    logic [2:0]   a_instruction, a_count;
    logic [1:0]   a_reg_addr;
    logic [8:0]   a_mem_address;
    logic [511:0] a_init;
    logic         b_in_ready, b_issued, b_illegal;
    logic [2:0]   b_instruction, b_count;
    logic [1:0]   b_reg_addr;
    logic [8:0]   b_mem_address;
    logic [511:0] b_init;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_issue_queue #(.DEPTH(4), .ISSUE_GAP(0)) u_gap0 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (a_in_ready),
        .in_opcode (in_opcode), .in_reg_addr (in_reg_addr), .in_mem_address (in_mem_address),
        .in_init_value (in_init_value), .flush (flush), .instruction (a_instruction),
        .reg_addr (a_reg_addr), .mem_address (a_mem_address), .initialize_value (a_init),
        .issued (a_issued), .illegal (a_illegal), .count (a_count)
    );

    instr_issue_queue #(.DEPTH(4), .ISSUE_GAP(3)) u_gap3 (
        .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (b_in_ready),
        .in_opcode (in_opcode), .in_reg_addr (in_reg_addr), .in_mem_address (in_mem_address),
        .in_init_value (in_init_value), .flush (flush), .instruction (b_instruction),
        .reg_addr (b_reg_addr), .mem_address (b_mem_address), .initialize_value (b_init),
        .issued (b_issued), .illegal (b_illegal), .count (b_count)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic present(input logic [2:0] op, input logic [8:0] mem, input logic [511:0] init);
        in_valid = 1'b1;
        in_opcode = op;
        in_mem_address = mem;
        in_init_value = init;
        in_reg_addr = mem[1:0];
    endtask

    logic [511:0] vec_a;
    logic [511:0] ones;
    int           exp_cnt3 [26];
    int           idx;
    logic         hs;
    logic         exp_iss;

    initial begin
        vec_a = '0;
        vec_a[31:0] = 32'd1;
        vec_a[319:288] = 32'd1048576;
        ones = '1;
        exp_cnt3 = '{1, 1, 2, 3, 4, 3, 4, 4, 4, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0};

        // Asynchronous reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_instr", 512'(a_instruction), 512'(3'b111));
        check_eq("rst_issued", 512'(a_issued), 512'(0));
        check_eq("rst_count", 512'(a_count), 512'(0));
        check_eq("rst_ready", 512'(a_in_ready), 512'(1));
        check_eq("rst_illegal", 512'(a_illegal), 512'(0));
        check_eq("rst_count_g3", 512'(b_count), 512'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single OP_INIT instruction through an empty queue
        present(3'b100, 9'd10, vec_a);
        tick();
        in_valid = 1'b0;
        check_eq("t1_count_push", 512'(a_count), 512'(1));
        check_eq("t1_issued_early", 512'(a_issued), 512'(0));
        tick();
        check_eq("t1_issued", 512'(a_issued), 512'(1));
        check_eq("t1_instr", 512'(a_instruction), 512'(3'b100));
        check_eq("t1_mem", 512'(a_mem_address), 512'(10));
        check_eq("t1_reg", 512'(a_reg_addr), 512'(2));
        check_eq("t1_init", a_init, vec_a);
        check_eq("t1_count_pop", 512'(a_count), 512'(0));
        tick();
        check_eq("t1_issued_off", 512'(a_issued), 512'(0));
        check_eq("t1_instr_nop", 512'(a_instruction), 512'(3'b111));
        check_eq("t1_init_nop", a_init, 512'(0));
        do_flush();

        // Illegal opcode in the middle of two legal ones
        present(3'b011, 9'd3, ones);
        tick();
        check_eq("t3a_count", 512'(a_count), 512'(1));
        check_eq("t3a_illegal", 512'(a_illegal), 512'(0));
        present(3'b110, 9'd6, ones);
        tick();
        check_eq("t3b_issued", 512'(a_issued), 512'(1));
        check_eq("t3b_instr", 512'(a_instruction), 512'(3'b011));
        check_eq("t3b_mem", 512'(a_mem_address), 512'(3));
        check_eq("t3b_init_zero", a_init, 512'(0));
        check_eq("t3b_count", 512'(a_count), 512'(0));
        check_eq("t3b_illegal", 512'(a_illegal), 512'(1));
        present(3'b001, 9'd1, ones);
        tick();
        in_valid = 1'b0;
        check_eq("t3c_issued", 512'(a_issued), 512'(0));
        check_eq("t3c_illegal", 512'(a_illegal), 512'(0));
        check_eq("t3c_count", 512'(a_count), 512'(1));
        tick();
        check_eq("t3d_issued", 512'(a_issued), 512'(1));
        check_eq("t3d_instr", 512'(a_instruction), 512'(3'b001));
        check_eq("t3d_mem", 512'(a_mem_address), 512'(1));
        check_eq("t3d_init_zero", a_init, 512'(0));
        check_eq("t3d_illegal", 512'(a_illegal), 512'(0));
        tick();
        check_eq("t3e_issued", 512'(a_issued), 512'(0));
        check_eq("t3e_count", 512'(a_count), 512'(0));
        do_flush();

        // Gap of 3: six back-to-back pushes against a four-entry queue
        idx = 0;
        for (int k = 1; k <= 26; k++) begin
            if (idx < 6) present(3'b000, 9'(idx), '0);
            else in_valid = 1'b0;
            hs = in_valid && b_in_ready;
            tick();
            if (hs) idx++;
            exp_iss = (k >= 2) && (k <= 22) && (((k - 2) % 4) == 0);
            check_eq($sformatf("t2_count_e%0d", k), 512'(b_count), 512'(exp_cnt3[k-1]));
            check_eq($sformatf("t2_ready_e%0d", k), 512'(b_in_ready),
                     512'(exp_cnt3[k-1] < 4));
            check_eq($sformatf("t2_issued_e%0d", k), 512'(b_issued), 512'(exp_iss));
            if (exp_iss)
                check_eq($sformatf("t2_mem_e%0d", k), 512'(b_mem_address), 512'((k - 2) / 4));
        end
        check_eq("t2_all_accepted", 512'(idx), 512'(6));
        do_flush();

        // Flush during GAP with three entries queued and a push pending
        for (int k = 0; k < 4; k++) begin
            present(3'b010, 9'(20 + k), '0);
            tick();
        end
        check_eq("t4_pre_count", 512'(b_count), 512'(3));
        check_eq("t4_pre_issued", 512'(b_issued), 512'(0));
        present(3'b010, 9'd99, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("t4_count", 512'(b_count), 512'(0));
        check_eq("t4_instr_nop", 512'(b_instruction), 512'(3'b111));
        check_eq("t4_issued", 512'(b_issued), 512'(0));
        check_eq("t4_illegal", 512'(b_illegal), 512'(0));
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq($sformatf("t4_quiet_%0d", k), 512'(b_issued), 512'(0));
        end
        do_flush();

        // No gap: ten-instruction stream, one push per cycle
        for (int k = 1; k <= 12; k++) begin
            if (k <= 10) present(3'b010, 9'(k - 1), '0);
            else in_valid = 1'b0;
            tick();
            exp_iss = (k >= 2) && (k <= 11);
            check_eq($sformatf("t5_issued_e%0d", k), 512'(a_issued), 512'(exp_iss));
            check_eq($sformatf("t5_ready_e%0d", k), 512'(a_in_ready), 512'(1));
            check_eq($sformatf("t5_count_e%0d", k), 512'(a_count), 512'(k <= 10 ? 1 : 0));
            if (exp_iss)
                check_eq($sformatf("t5_mem_e%0d", k), 512'(a_mem_address), 512'(k - 2));
        end

        // Reset between edges while an instruction is on the outputs
        present(3'b100, 9'd10, vec_a);
        tick();
        present(3'b001, 9'd11, '0);
        tick();
        in_valid = 1'b0;
        check_eq("t6_pre_issued", 512'(a_issued), 512'(1));
        check_eq("t6_pre_count", 512'(a_count), 512'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_issued", 512'(a_issued), 512'(0));
        check_eq("t6_instr", 512'(a_instruction), 512'(3'b111));
        check_eq("t6_mem", 512'(a_mem_address), 512'(0));
        check_eq("t6_init", a_init, 512'(0));
        check_eq("t6_count", 512'(a_count), 512'(0));
        check_eq("t6_ready", 512'(a_in_ready), 512'(1));
        check_eq("t6_count_g3", 512'(b_count), 512'(0));
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq($sformatf("t6_abandoned_%0d", k), 512'(a_issued), 512'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_issue_queue.md
INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

Interface
REQ-001 Parameter DEPTH, 4, instruction FIFO entries (power of two, >=2).
REQ-002 Parameter ISSUE_GAP, 0, NOP cycles forced after each issued instruction (0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  host presents an instruction.
REQ-006 in_ready  output  1  queue accepts; equals (count < DEPTH), independent of in_valid.
REQ-007 in_opcode  input  3  instruction opcode.
REQ-008 in_reg_addr  input  2  target vector register.
REQ-009 in_mem_address  input  9  memory word address.
REQ-010 in_init_value  input  512  16 x 32-bit lane payload; stored for opcode 3'b100, stored as zero otherwise.
REQ-011 flush  input  1  discard queue contents and abort any gap.
REQ-012 instruction  output  3  opcode to the Cpu.
REQ-013 reg_addr  output  2  register address to the Cpu.
REQ-014 mem_address  output  9  memory address to the Cpu.
REQ-015 initialize_value  output  512  payload to the Cpu.
REQ-016 issued  output  1  high exactly in cycles where the outputs carry a real instruction.
REQ-017 illegal  output  1  one-cycle pulse after an illegal opcode is consumed.
REQ-018 count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 Push occurs on an edge where in_valid && in_ready; legal opcodes 3'b000..3'b100 are written at the write pointer.
REQ-020 Opcodes 3'b101, 3'b110, 3'b111 complete the handshake, are not stored, and pulse illegal on the following cycle.
REQ-021 All Cpu-side outputs are registered; NOP output state is instruction=3'b111, reg_addr=0, mem_address=0, initialize_value=0, issued=0.
REQ-022 FSM states IDLE, ISSUE, GAP; IDLE drives NOP and moves to ISSUE at the first edge with count != 0, popping the head into the output registers.
REQ-023 ISSUE lasts exactly one cycle with issued=1; next edge: ISSUE_GAP>0 -> GAP with counter loaded ISSUE_GAP-1; else pop again if count != 0 (stay ISSUE), otherwise IDLE.
REQ-024 GAP drives NOP; at counter 0 it behaves as REQ-023 with ISSUE_GAP=0 (pop if non-empty, else IDLE).
REQ-025 Latency: legal instruction pushed at edge N into an empty queue in IDLE is on the outputs from edge N+1 until edge N+2.
REQ-026 Simultaneous push and pop leaves count unchanged; read and write pointers wrap modulo DEPTH; issue order equals acceptance order.
REQ-027 flush is synchronous and highest priority: next edge count=0, pointers=0, state IDLE, outputs NOP, any same-cycle push discarded, no illegal pulse.

Reset
REQ-028 rst_n low forces immediately, without a clock: state IDLE, count 0, pointers 0, outputs in NOP state, illegal 0, gap counter 0; in_ready therefore reads 1.
REQ-029 FIFO storage is not reset; reset mid-issue abandons the in-flight and queued instructions.

Structure
REQ-030 Shared package cpu_pkg holds OP_INIT=3'b100, OP_NOP=3'b111, OP_MAX_LEGAL=3'b100, LANES=16, LANE_W=32, VEC_W=512, MEM_AW=9, REG_AW=2, and the issue-state enum.
REQ-031 Storage and pointers are one sub-module iq_fifo (write, read, count, full/empty); FSM and output registers stay in the top.

Verification
REQ-032 Reset, push {100, reg 00, mem 10, lane0=1, lane9=1048576} -> one cycle later instruction=100, mem_address=10, issued=1 for one cycle, then NOP, count 0.
REQ-033 ISSUE_GAP=3, push 6 back-to-back legal instructions mem 0..5 -> in_ready low once count=4, issues exactly 4 cycles apart, mem order 0..5.
REQ-034 Push 011, 110, 001 -> illegal pulses once, only 011 then 001 issued.
REQ-035 ISSUE_GAP=3, flush asserted during GAP with count=3 and in_valid high -> next edge count=0, NOP outputs, pushed instruction never issued.
REQ-036 ISSUE_GAP=0, stream 10 instructions mem 0..9 every cycle -> issued high 10 consecutive cycles, in_ready always 1, count <= 1, pointers wrap.
REQ-037 Assert rst_n low between edges while issued=1 -> outputs NOP and count 0 before the next rising edge.
